spi_prog_loader: RTL
====================

SPI_PROG_LOADER -- requirements
Module: spi_prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: maximum program length in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-003 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI input.
REQ-004 clk  in  1  system clock; the single clock of the block.
REQ-005 rst  in  1  reset; synchronous to clk, active-high.
REQ-006 spi_sclk  in  1  SPI clock from host (mode 0), asynchronous to clk.
REQ-007 spi_cs_n  in  1  SPI chip select from host, active-low, asynchronous.
REQ-008 spi_mosi  in  1  SPI data from host; MSB first.
REQ-009 core_adr  in  32  core memory address.
REQ-010 core_wdata  in  32  core write data.
REQ-011 core_we  in  1  core memory write enable.
REQ-012 mem_adr  out  32  address to unified memory.
REQ-013 mem_wdata  out  32  write data to unified memory.
REQ-014 mem_we  out  1  write enable to unified memory.
REQ-015 core_select  out  1  1 = core owns memory and runs; 0 = core held, loader owns memory.
REQ-016 load_err  out  1  sticky error flag, cleared only at the start of the next frame or by rst.

Function
REQ-017 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops; a sclk rising edge is detected from the synchronized sclk, and mosi is sampled on that edge.
REQ-018 Correct operation SHALL require a clk frequency of at least 8x the sclk frequency; no behaviour is guaranteed below that ratio.
REQ-019 FSM states SHALL be IDLE, HEADER, LOAD, WAIT_CS, RUN and ERROR.
REQ-020 IDLE: on the synchronized cs_n falling edge, clear load_err, bit counter and word counter, then go to HEADER.
REQ-021 HEADER: shift 32 bits into the word count N; after the 32nd bit, go to WAIT_CS if N==0, to ERROR if N>MAX_WORDS, otherwise to LOAD.
REQ-022 LOAD: shift 32 bits per word; one clk after the 32nd sampled bit, drive mem_we=1 for exactly one cycle, with mem_adr=BASE_ADDR+4*k and mem_wdata=word k, then increment k.
REQ-023 LOAD: when k reaches N, go to WAIT_CS; any bits received in WAIT_CS SHALL be ignored.
REQ-024 WAIT_CS: on the synchronized cs_n rising edge, go to RUN.
REQ-025 A cs_n rising edge in HEADER or LOAD SHALL discard the partial word, set load_err and go to ERROR; words already written stay in memory.
REQ-026 ERROR: core_select=0; on a cs_n falling edge, go to HEADER with load_err cleared.
REQ-027 RUN: core_select=1; mem_adr, mem_wdata and mem_we SHALL pass core_adr, core_wdata and core_we through combinationally.
REQ-028 RUN: a cs_n falling edge SHALL drop core_select to 0 on the same clk edge as the state change to HEADER, which starts a reload.
REQ-029 While core_select=0, core_we SHALL be ignored and mem_we SHALL be driven only by the loader.
REQ-030 core_select SHALL be registered (glitch-free) and SHALL change only on a state transition into or out of RUN.
REQ-031 Word counter SHALL be sized for MAX_WORDS; the address SHALL be computed in 32 bits and wrap modulo 2^32.

Reset
REQ-032 On rst: state=IDLE, core_select=0, load_err=0, mem_we=0, counters and shift registers cleared, and synchronizer flops set to idle levels (sclk=0, cs_n=1, mosi=0).
REQ-033 rst asserted mid-frame SHALL abort the frame with no further memory write; the host must then start a new frame.

Structure
REQ-034 State encoding, HDR_BITS=32 and WORD_BITS=32 SHALL live in the shared package used by the core.
REQ-035 A sub-module spi_sync_edge SHALL contain the synchronizer and the sclk-rise and cs_n-rise/fall edge detection; everything else lives in the top level.

Verification
REQ-036 Bench SHALL cover: header N=3, words 0x00000013, 0xDEADBEEF, 0x12345678, then cs_n high -> three mem_we pulses at 0x0, 0x4 and 0x8 with matching data, then core_select=1.
REQ-037 Bench SHALL cover: header N=0, then cs_n high -> no mem_we pulse, core_select=1, load_err=0.
REQ-038 Bench SHALL cover: header N=1025 -> ERROR, load_err=1, core_select=0, no writes.
REQ-039 Bench SHALL cover: N=2 with cs_n high after 20 bits of word 1 -> exactly one write at 0x0, load_err=1, core_select=0.
REQ-040 Bench SHALL cover: in RUN with core_we=1 at core_adr=0x100, pull cs_n low -> core_select=0 on that clk edge, core write no longer reaches mem_we, and the reload completes correctly.
REQ-041 Bench SHALL cover: rst pulse during LOAD bit 16 -> all outputs return to reset values and no spurious mem_we occurs.

Source files
------------

// File: rtl/spi_prog_loader_pkg.sv
// Shared definitions for the SPI program loader: FSM encoding, frame field
// widths and the word-index to byte-address helper.
package spi_prog_loader_pkg;

  localparam int HDR_BITS  = 32;
  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    LOAD    = 3'd2,
    WAIT_CS = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } state_t;

  // Word k lands at base + 4*k; the sum wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and derives the
// sclk rising edge plus the chip-select falling and rising edges.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;

  // mosi uses the same chain depth as sclk so the data bit stays aligned with its edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync[0] <= spi_sclk;
      cs_sync[0]   <= spi_cs_n;
      mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sclk_q <= sclk_sync[SYNC_STAGES-1];
      cs_q   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_q;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_q;
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_prog_loader.sv
// SPI boot loader: receives a word-count header and program words over SPI,
// writes them into unified memory, then hands the memory port to the core.
module spi_prog_loader
  import spi_prog_loader_pkg::*;
#(
  parameter int          MAX_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        core_select,
  output logic        load_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam logic [BIT_W-1:0] HDR_LAST  = BIT_W'(HDR_BITS - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_BITS - 1);

  logic                 sclk_rise;
  logic                 cs_fall;
  logic                 cs_rise;
  logic                 mosi_s;

  state_t               state;
  logic [WORD_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [31:0]          word_n;
  logic [CNT_W-1:0]     word_cnt;
  logic [31:0]          ld_adr;
  logic [31:0]          ld_wdata;
  logic                 ld_we;

  logic [WORD_BITS-1:0] word_in;
  logic [CNT_W-1:0]     next_cnt;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .sclk_rise(sclk_rise),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  assign word_in  = {shreg[WORD_BITS-2:0], mosi_s};
  assign next_cnt = word_cnt + CNT_W'(1);

  // Loader FSM; the write strobe is registered so it fires one clk after the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      core_select <= 1'b0;
      load_err    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_n      <= '0;
      word_cnt    <= '0;
      ld_adr      <= '0;
      ld_wdata    <= '0;
      ld_we       <= 1'b0;
    end else begin
      ld_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            load_err <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            state    <= HEADER;
          end
        end

        HEADER: begin
          if (cs_rise) begin
            load_err <= 1'b1;
            state    <= ERROR;
          end else if (sclk_rise) begin
            shreg   <= word_in;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == HDR_LAST) begin
              bit_cnt <= '0;
              word_n  <= word_in;
              if (word_in == '0) begin
                state <= WAIT_CS;
              end else if (word_in > 32'(MAX_WORDS)) begin
                load_err <= 1'b1;
                state    <= ERROR;
              end else begin
                state <= LOAD;
              end
            end
          end
        end

        LOAD: begin
          if (cs_rise) begin
            load_err <= 1'b1;
            state    <= ERROR;
          end else if (sclk_rise) begin
            shreg   <= word_in;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == WORD_LAST) begin
              bit_cnt  <= '0;
              ld_we    <= 1'b1;
              ld_wdata <= word_in;
              ld_adr   <= word_addr(BASE_ADDR, 32'(word_cnt));
              word_cnt <= next_cnt;
              if (32'(next_cnt) == word_n) begin
                state <= WAIT_CS;
              end
            end
          end
        end

        WAIT_CS: begin
          if (cs_rise) begin
            core_select <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (cs_fall) begin
            core_select <= 1'b0;
            load_err    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            state       <= HEADER;
          end
        end

        ERROR: begin
          if (cs_fall) begin
            load_err <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            state    <= HEADER;
          end
        end

        default: begin
          core_select <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign mem_adr   = core_select ? core_adr   : ld_adr;
  assign mem_wdata = core_select ? core_wdata : ld_wdata;
  assign mem_we    = core_select ? core_we    : ld_we;

endmodule
